// File: rtl/gate_pkg.sv
// Shared encodings for the gate vector sequencer: gate selector codes and FSM states.
package gate_pkg;

    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_XOR  = 3'd2;
    localparam logic [2:0] GATE_NAND = 3'd3;
    localparam logic [2:0] GATE_NOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden model: expected gate output for a selector and input vector,
// plus a flag telling whether the selector names a real gate.
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic [2:0]      sel_i,
    input  logic [N_IN-1:0] vec_i,
    output logic            y_o,
    output logic            legal_o
);

    // Reduction operators give the N-input gate directly; codes 6/7 are reserved.
    always_comb begin
        y_o     = 1'b0;
        legal_o = 1'b1;
        case (sel_i)
            GATE_AND:  y_o = &vec_i;
            GATE_OR:   y_o = |vec_i;
            GATE_XOR:  y_o = ^vec_i;
            GATE_NAND: y_o = ~&vec_i;
            GATE_NOR:  y_o = ~|vec_i;
            GATE_XNOR: y_o = ~^vec_i;
            default:   legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_vector_sequencer.sv
// Exhaustive stimulus sequencer for N-input gate blocks: walks every input vector,
// holds it HOLD_CYCLES clocks, checks the DUT output on the last hold cycle and
// records a saturating error count and the first failing vector.
module gate_vector_sequencer
    import gate_pkg::*;
#(
    parameter int N_IN        = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       gate_sel,
    output logic [N_IN-1:0]  vec,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [N_IN-1:0]  first_fail_vec
);

    localparam int               CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = '1;
    localparam logic [ERR_W-1:0] ERR_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IN-1:0]  vec_q, vec_d;
    logic [2:0]       sel_q, sel_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [N_IN-1:0]  ffv_q, ffv_d;
    logic             pass_q, pass_d;

    logic             ref_y;
    logic             ref_legal;
    logic             start_legal;
    logic             mismatch;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .sel_i   (sel_q),
        .vec_i   (vec_q),
        .y_o     (ref_y),
        .legal_o (ref_legal)
    );

    assign start_legal = (gate_sel <= GATE_XNOR);

    // Next-state logic: start handling in IDLE/DONE, hold/compare/advance in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vec_d    = vec_q;
        sel_d    = sel_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        pass_d   = pass_q;
        mismatch = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    sel_d   = gate_sel;
                    err_d   = '0;
                    ffv_d   = '0;
                    pass_d  = 1'b0;
                    vec_d   = '0;
                    cnt_d   = '0;
                    // A reserved selector finishes at once with a failing result.
                    state_d = start_legal ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    // Any DUT latency has settled by the last hold cycle.
                    mismatch = (dut_y != ref_y) || !ref_legal;
                    if (mismatch) begin
                        if (err_q != ERR_MAX) err_d = err_q + 1'b1;
                        if (err_q == '0)      ffv_d = vec_q;
                    end
                    if (vec_q == VEC_LAST) begin
                        // Final vector's mismatch is folded in before done rises.
                        state_d = S_DONE;
                        pass_d  = (err_q == '0) && !mismatch;
                    end else begin
                        vec_d = vec_q + 1'b1;
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            vec_q   <= '0;
            sel_q   <= '0;
            err_q   <= '0;
            ffv_q   <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            ffv_q   <= ffv_d;
            pass_q  <= pass_d;
        end
    end

    assign vec            = vec_q;
    assign busy           = (state_q == S_RUN);
    assign done           = (state_q == S_DONE);
    assign pass           = pass_q;
    assign err_count      = err_q;
    assign first_fail_vec = ffv_q;

endmodule
